// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin tristate bus arbiter with hold limit, dead-time gap and bus capture
// Grants one driver at a time, then forces an all-off gap before the next grant.
module tristate_bus_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic       BUS_IN,
  output logic [3:0] EN,
  output logic [1:0] SRC,
  output logic       DATA_OUT,
  output logic       DATA_VALID
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_d;
  logic [1:0] owner, owner_d;
  logic [1:0] last_owner, last_owner_d;
  logic [7:0] hold_cnt, hold_d;
  logic [3:0] gap_cnt, gap_d;
  logic [3:0] en_d;
  logic [1:0] src_d;
  logic       dout_d;
  logic       valid_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Search starts just after the previous owner, so the previous owner is tried last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = 2'(last_owner + 2'(k));
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    hold_d       = hold_cnt;
    gap_d        = gap_cnt;
    en_d         = EN;
    src_d        = SRC;
    dout_d       = DATA_OUT;
    valid_d      = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          en_d    = 4'b0001 << win_idx;
          owner_d = win_idx;
          hold_d  = 8'(HOLD_CYCLES);
        end
      end

      GRANT: begin
        dout_d  = BUS_IN;
        src_d   = owner;
        valid_d = 1'b1;
        // Leave on the last hold cycle or as soon as the owner lets go.
        if (hold_cnt <= 8'd1 || !REQ[owner]) begin
          state_d      = GAP;
          en_d         = 4'b0000;
          last_owner_d = owner;
          hold_d       = 8'd0;
          gap_d        = 4'(GAP_CYCLES);
        end else begin
          hold_d = 8'(hold_cnt - 8'd1);
        end
      end

      GAP: begin
        if (gap_cnt <= 4'd1) begin
          gap_d = 4'd0;
          if (win_found) begin
            state_d = GRANT;
            en_d    = 4'b0001 << win_idx;
            owner_d = win_idx;
            hold_d  = 8'(HOLD_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = 4'(gap_cnt - 4'd1);
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd3;
      hold_cnt   <= 8'd0;
      gap_cnt    <= 4'd0;
      EN         <= 4'b0000;
      SRC        <= 2'd0;
      DATA_OUT   <= 1'b0;
      DATA_VALID <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      hold_cnt   <= hold_d;
      gap_cnt    <= gap_d;
      EN         <= en_d;
      SRC        <= src_d;
      DATA_OUT   <= dout_d;
      DATA_VALID <= valid_d;
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - vector-table bench for tristate_bus_arbiter
// Each row drives inputs, takes one rising edge, then compares registered outputs.
module tb_tristate_bus_arbiter;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;
  logic       BUS_IN;
  logic [3:0] EN;
  logic [1:0] SRC;
  logic       DATA_OUT;
  logic       DATA_VALID;

  int errors = 0;
  int checks = 0;
  logic [3:0] prev_en = 4'b0000;

  tristate_bus_arbiter #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ        (REQ),
    .BUS_IN     (BUS_IN),
    .EN         (EN),
    .SRC        (SRC),
    .DATA_OUT   (DATA_OUT),
    .DATA_VALID (DATA_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       bus;
    logic [3:0] en;
    logic       dv;
    logic       dout;
    logic [1:0] src;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic bus,
                     input logic [3:0] en, input logic dv, input logic dout,
                     input logic [1:0] src);
    vec_t v;
    v.rst = rst; v.req = req; v.bus = bus; v.en = en;
    v.dv = dv; v.dout = dout; v.src = src;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic check_en_safety(input string name, input int idx);
    checks++;
    if (!$onehot0(EN) || (prev_en != 4'b0000 && EN != 4'b0000 && EN != prev_en)) begin
      errors++;
      $display("FAIL %s row %0d: EN %b after %b is not one-hot/break-before-make", name, idx, EN, prev_en);
    end
    prev_en = EN;
  endtask

  task automatic add_grant(input logic [3:0] req, input logic [3:0] en, input logic [1:0] src);
    add(1'b0, req, 1'b0, en, 1'b0, 1'b0, 2'd0);
    add(1'b0, req, 1'b0, en, 1'b1, 1'b0, src);
    add(1'b0, req, 1'b1, en, 1'b1, 1'b1, src);
    add(1'b0, req, 1'b0, en, 1'b1, 1'b0, src);
    add(1'b0, req, 1'b1, 4'b0000, 1'b1, 1'b1, src);
  endtask

  initial begin
    RST = 1'b1;
    REQ = 4'b1111;
    BUS_IN = 1'b0;

    // Reset with all requesting, then round robin 0,1,2,3,0 with captures on driver 0.
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0);
    add(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0);
    add_grant(4'b1111, 4'b0010, 2'd1);
    add_grant(4'b1111, 4'b0100, 2'd2);
    add_grant(4'b1111, 4'b1000, 2'd3);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);

    // Single requester 2 gets repeated 4-cycle grants with a one-cycle gap.
    add(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    add_grant(4'b0100, 4'b0100, 2'd2);
    add_grant(4'b0100, 4'b0100, 2'd2);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0);

    // Early release by driver 1; non-owner bit 3 toggling must not disturb it.
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd0);
    add(1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1);
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd1);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      RST = vecs[i].rst;
      REQ = vecs[i].req;
      BUS_IN = vecs[i].bus;
      @(posedge CLK);
      #1;
      check("en", i, EN, vecs[i].en);
      check("data_valid", i, {3'b000, DATA_VALID}, {3'b000, vecs[i].dv});
      if (vecs[i].dv) begin
        check("data_out", i, {3'b000, DATA_OUT}, {3'b000, vecs[i].dout});
        check("src", i, {2'b00, SRC}, {2'b00, vecs[i].src});
      end
      check_en_safety("en_safety", i);
    end

    // Asynchronous reset in the third cycle of a grant to driver 3.
    RST = 1'b1;
    REQ = 4'b1000;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("async_grant3", 100, EN, 4'b1000);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    check("async_pre_pulse", 101, EN, 4'b1000);
    RST = 1'b1;
    #1;
    check("async_en_drop", 102, EN, 4'b0000);
    check("async_dv_drop", 103, {3'b000, DATA_VALID}, 4'b0000);
    #1;
    RST = 1'b0;
    REQ = 4'b1001;
    @(posedge CLK);
    #1;
    check("after_async_first", 104, EN, 4'b0001);
    check("after_async_dv", 105, {3'b000, DATA_VALID}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
